// File: rtl/gwa_param.sv
// gwa_param: change machine, takes 1/2 EUR coins into a bounded credit and pays 20c/10c change from tracked stocks.
// Latency: decision on the edge after WT/CANCEL, then one ejector pulse every two cycles; rejects one cycle after the coin.
// Backpressure: none; coins over the credit limit, or arriving while busy or with WT/CANCEL, go to the reject chute.
// Optional: define GWA_EDGE_DET_EN to rising-edge detect EU1/EU2/WT/CANCEL/REFILL (one extra cycle on every decision).
module gwa_param #(
    parameter int CREDIT_W     = 7,
    parameter int MAX_CREDIT   = 60,
    parameter int STOCK_W      = 8,
    parameter int STOCK20_INIT = 50,
    parameter int STOCK10_INIT = 50
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                EU1,
    input  logic                EU2,
    input  logic                WT,
    input  logic                CANCEL,
    input  logic                REFILL,
    output logic                C10_O,
    output logic                C20_O,
    output logic                EU1_O,
    output logic                EU2_O,
    output logic                REJ1_O,
    output logic                REJ2_O,
    output logic                BUSY,
    output logic [CREDIT_W-1:0] CREDIT,
    output logic [STOCK_W-1:0]  STOCK10,
    output logic [STOCK_W-1:0]  STOCK20
);
    localparam int CW1 = CREDIT_W + 1;
    localparam int DW  = ((CREDIT_W > STOCK_W) ? CREDIT_W : STOCK_W) + 1;
    localparam logic [CW1-1:0]      MAX_C    = CW1'(MAX_CREDIT);
    localparam logic [CREDIT_W-1:0] TWO      = CREDIT_W'(2);
    localparam logic [CREDIT_W-1:0] ONE      = CREDIT_W'(1);
    localparam logic [CREDIT_W-1:0] TEN      = CREDIT_W'(10);
    localparam logic [CREDIT_W-1:0] TWENTY   = CREDIT_W'(20);
    localparam logic [STOCK_W-1:0]  S20_INIT = STOCK_W'(STOCK20_INIT);
    localparam logic [STOCK_W-1:0]  S10_INIT = STOCK_W'(STOCK10_INIT);

    typedef enum logic [2:0] {IDLE, PAY_PULSE, PAY_GAP, REF_PULSE, REF_GAP} state_t;
    state_t state, state_nxt;

    logic eu1_p, eu2_p, wt_p, cancel_p, refill_p;

`ifdef GWA_EDGE_DET_EN
    logic [4:0] in_prev, in_edge;
    // Registered rising-edge detect so a held level counts as a single event
    always_ff @(posedge clk) begin
        if (rst) begin
            in_prev <= '0;
            in_edge <= '0;
        end else begin
            in_prev <= {EU1, EU2, WT, CANCEL, REFILL};
            in_edge <= {EU1, EU2, WT, CANCEL, REFILL} & ~in_prev;
        end
    end
    assign {eu1_p, eu2_p, wt_p, cancel_p, refill_p} = in_edge;
`else
    assign eu1_p    = EU1;
    assign eu2_p    = EU2;
    assign wt_p     = WT;
    assign cancel_p = CANCEL;
    assign refill_p = REFILL;
`endif

    logic [CREDIT_W-1:0] credit_q, credit_nxt;
    logic [STOCK_W-1:0]  stock10_q, stock20_q, s10_nxt, s20_nxt;
    logic c10_nxt, c20_nxt, e1_nxt, e2_nxt, r1_nxt, r2_nxt;

    // Feasibility of exact change: greedy 20c count, remainder must fit the 10c stock
    logic [DW-1:0] credit_dw, half_credit, n20, rem;
    logic          pay_ok, have_credit, idle_action;
    assign credit_dw   = DW'(credit_q);
    assign half_credit = credit_dw >> 1;
    assign n20         = (DW'(stock20_q) < half_credit) ? DW'(stock20_q) : half_credit;
    assign rem         = credit_dw - (n20 << 1);
    assign pay_ok      = rem <= DW'(stock10_q);
    assign have_credit = credit_q != '0;
    assign idle_action = (cancel_p || wt_p) && have_credit;

    // One guard bit so over-limit sums compare correctly
    logic [CW1-1:0] sum1, sum2, sum3;
    assign sum1 = CW1'(credit_q) + CW1'(10);
    assign sum2 = CW1'(credit_q) + CW1'(20);
    assign sum3 = CW1'(credit_q) + CW1'(30);

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state: CANCEL beats WT; pay only when exact change is possible
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (cancel_p && have_credit)  state_nxt = REF_PULSE;
                else if (wt_p && have_credit) state_nxt = pay_ok ? PAY_PULSE : REF_PULSE;
            end
            PAY_PULSE: state_nxt = PAY_GAP;
            PAY_GAP:   state_nxt = have_credit ? PAY_PULSE : IDLE;
            REF_PULSE: state_nxt = REF_GAP;
            REF_GAP:   state_nxt = have_credit ? REF_PULSE : IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    // Next values of the registered outputs, credit and stocks
    always_comb begin
        credit_nxt = credit_q;
        s10_nxt    = stock10_q;
        s20_nxt    = stock20_q;
        c10_nxt    = 1'b0;
        c20_nxt    = 1'b0;
        e1_nxt     = 1'b0;
        e2_nxt     = 1'b0;
        r1_nxt     = eu1_p;
        r2_nxt     = eu2_p;
        case (state)
            IDLE: begin
                if (!idle_action) begin
                    r1_nxt = 1'b0;
                    r2_nxt = 1'b0;
                    if (eu1_p && eu2_p) begin
                        if (sum3 <= MAX_C) begin
                            credit_nxt = sum3[CREDIT_W-1:0];
                        end else if (sum1 <= MAX_C) begin
                            credit_nxt = sum1[CREDIT_W-1:0];
                            r2_nxt     = 1'b1;
                        end else begin
                            r1_nxt = 1'b1;
                            r2_nxt = 1'b1;
                        end
                    end else if (eu1_p) begin
                        if (sum1 <= MAX_C) credit_nxt = sum1[CREDIT_W-1:0];
                        else               r1_nxt     = 1'b1;
                    end else if (eu2_p) begin
                        if (sum2 <= MAX_C) credit_nxt = sum2[CREDIT_W-1:0];
                        else               r2_nxt     = 1'b1;
                    end
                end
                if (refill_p) begin
                    s10_nxt = S10_INIT;
                    s20_nxt = S20_INIT;
                end
            end
            PAY_PULSE: begin
                if (credit_q >= TWO && stock20_q != '0) begin
                    c20_nxt    = 1'b1;
                    credit_nxt = credit_q - TWO;
                    s20_nxt    = stock20_q - 1'b1;
                end else begin
                    c10_nxt    = 1'b1;
                    credit_nxt = credit_q - ONE;
                    s10_nxt    = stock10_q - 1'b1;
                end
            end
            REF_PULSE: begin
                if (credit_q >= TWENTY) begin
                    e2_nxt     = 1'b1;
                    credit_nxt = credit_q - TWENTY;
                end else begin
                    e1_nxt     = 1'b1;
                    credit_nxt = credit_q - TEN;
                end
            end
            default: ;
        endcase
    end

    // Output, credit and stock registers
    always_ff @(posedge clk) begin
        if (rst) begin
            credit_q  <= '0;
            stock10_q <= S10_INIT;
            stock20_q <= S20_INIT;
            C10_O     <= 1'b0;
            C20_O     <= 1'b0;
            EU1_O     <= 1'b0;
            EU2_O     <= 1'b0;
            REJ1_O    <= 1'b0;
            REJ2_O    <= 1'b0;
        end else begin
            credit_q  <= credit_nxt;
            stock10_q <= s10_nxt;
            stock20_q <= s20_nxt;
            C10_O     <= c10_nxt;
            C20_O     <= c20_nxt;
            EU1_O     <= e1_nxt;
            EU2_O     <= e2_nxt;
            REJ1_O    <= r1_nxt;
            REJ2_O    <= r2_nxt;
        end
    end

    assign BUSY    = (state != IDLE);
    assign CREDIT  = credit_q;
    assign STOCK10 = stock10_q;
    assign STOCK20 = stock20_q;
endmodule

// File: tb/tb_gwa_param.sv
module tb_gwa_param;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       eu1 = 1'b0, eu2 = 1'b0, wt = 1'b0, cancel = 1'b0, refill = 1'b0;
    logic       c10_o, c20_o, eu1_o, eu2_o, rej1_o, rej2_o, busy;
    logic [6:0] credit;
    logic [7:0] stock10, stock20;

    always #5 clk = ~clk;

    gwa_param dut (
        .clk(clk), .rst(rst), .EU1(eu1), .EU2(eu2), .WT(wt), .CANCEL(cancel), .REFILL(refill),
        .C10_O(c10_o), .C20_O(c20_o), .EU1_O(eu1_o), .EU2_O(eu2_o),
        .REJ1_O(rej1_o), .REJ2_O(rej2_o), .BUSY(busy),
        .CREDIT(credit), .STOCK10(stock10), .STOCK20(stock20)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Output monitor: pulse counts, back-to-back pulse and 20c-after-10c detection
    int n10 = 0, n20 = 0, ne1 = 0, ne2 = 0, nr1 = 0, nr2 = 0;
    int viol = 0, order_viol = 0;
    bit seen10 = 1'b0;
    logic [3:0] prev = 4'b0;
    always @(posedge clk) begin
        #1;
        if (c10_o)  n10++;
        if (c20_o)  n20++;
        if (eu1_o)  ne1++;
        if (eu2_o)  ne2++;
        if (rej1_o) nr1++;
        if (rej2_o) nr2++;
        if ((prev & {c10_o, c20_o, eu1_o, eu2_o}) != 4'b0) viol++;
        prev = {c10_o, c20_o, eu1_o, eu2_o};
        if (c10_o) seen10 = 1'b1;
        if (c20_o && seen10) order_viol++;
    end

    // Behavioural reference model, in 10c units
    localparam int MAXC = 60;
    localparam int INIT = 50;
    int m_credit = 0, m_s10 = INIT, m_s20 = INIT, in_units = 0;

    localparam int OP_EU1 = 0, OP_EU2 = 1, OP_BOTH = 2, OP_WT = 3, OP_CANCEL = 4,
                   OP_REFILL = 5, OP_WT_COIN = 6;

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 300 && busy; i++) @(negedge clk);
        chk({tag, " idle"}, int'(busy), 0);
    endtask

    task automatic do_op(input int op, input string tag);
        int b10, b20, be1, be2, br1, br2;
        int x10, x20, xe1, xe2, xr1, xr2;
        int c, k20, r;
        bit action;
        b10 = n10; b20 = n20; be1 = ne1; be2 = ne2; br1 = nr1; br2 = nr2;
        x10 = 0; x20 = 0; xe1 = 0; xe2 = 0; xr1 = 0; xr2 = 0;
        seen10 = 1'b0;
        c = m_credit;
        action = (op == OP_WT || op == OP_CANCEL || op == OP_WT_COIN) && c > 0;
        if (op == OP_EU1 || op == OP_WT_COIN) begin
            in_units += 10;
            if (!action && m_credit + 10 <= MAXC) m_credit += 10;
            else xr1 = 1;
        end
        if (op == OP_EU2) begin
            in_units += 20;
            if (m_credit + 20 <= MAXC) m_credit += 20;
            else xr2 = 1;
        end
        if (op == OP_BOTH) begin
            in_units += 30;
            if (m_credit + 30 <= MAXC) m_credit += 30;
            else if (m_credit + 10 <= MAXC) begin m_credit += 10; xr2 = 1; end
            else begin xr1 = 1; xr2 = 1; end
        end
        if (action) begin
            k20 = (m_s20 < c / 2) ? m_s20 : c / 2;
            r = c - 2 * k20;
            if (op != OP_CANCEL && r <= m_s10) begin
                x20 = k20; x10 = r; m_s20 -= k20; m_s10 -= r;
            end else begin
                xe2 = c / 20; xe1 = (c % 20) / 10;
            end
            m_credit = 0;
        end
        if (op == OP_REFILL) begin m_s10 = INIT; m_s20 = INIT; end

        @(negedge clk);
        eu1    = (op == OP_EU1 || op == OP_BOTH || op == OP_WT_COIN);
        eu2    = (op == OP_EU2 || op == OP_BOTH);
        wt     = (op == OP_WT || op == OP_WT_COIN);
        cancel = (op == OP_CANCEL);
        refill = (op == OP_REFILL);
        @(negedge clk);
        {eu1, eu2, wt, cancel, refill} = 5'b0;
        wait_idle(tag);
        chk({tag, " c10"},  n10 - b10, x10);
        chk({tag, " c20"},  n20 - b20, x20);
        chk({tag, " eu1_o"}, ne1 - be1, xe1);
        chk({tag, " eu2_o"}, ne2 - be2, xe2);
        chk({tag, " rej1"}, nr1 - br1, xr1);
        chk({tag, " rej2"}, nr2 - br2, xr2);
        chk({tag, " credit"},  int'(credit),  m_credit);
        chk({tag, " stock10"}, int'(stock10), m_s10);
        chk({tag, " stock20"}, int'(stock20), m_s20);
    endtask

    typedef struct {
        bit eu1, eu2, wt, cancel;
        int credit;
        bit rej1, rej2, busy;
    } vec_t;
    vec_t tbl[9];

    initial begin
        int b20, br1, op;

        tbl[0] = '{0, 0, 1, 0,  0, 0, 0, 0};  // WT with no credit: nothing
        tbl[1] = '{0, 0, 0, 1,  0, 0, 0, 0};  // CANCEL with no credit: nothing
        tbl[2] = '{0, 1, 0, 0, 20, 0, 0, 0};
        tbl[3] = '{1, 1, 0, 0, 50, 0, 0, 0};
        tbl[4] = '{1, 1, 0, 0, 60, 0, 1, 0};  // only EU1 fits
        tbl[5] = '{1, 0, 0, 0, 60, 1, 0, 0};  // at limit
        tbl[6] = '{0, 1, 0, 0, 60, 0, 1, 0};
        tbl[7] = '{1, 1, 0, 0, 60, 1, 1, 0};
        tbl[8] = '{0, 0, 0, 0, 60, 0, 0, 0};

        // Reset state
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("reset credit",  int'(credit), 0);
        chk("reset stock10", int'(stock10), INIT);
        chk("reset stock20", int'(stock20), INIT);
        chk("reset busy",    int'(busy), 0);
        chk("reset pulses",  int'({c10_o, c20_o, eu1_o, eu2_o, rej1_o, rej2_o}), 0);

        // Coin acceptance table
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            eu1 = tbl[i].eu1; eu2 = tbl[i].eu2; wt = tbl[i].wt; cancel = tbl[i].cancel;
            in_units += int'(tbl[i].eu1) * 10 + int'(tbl[i].eu2) * 20;
            @(posedge clk); #1;
            chk($sformatf("tbl%0d credit", i), int'(credit), tbl[i].credit);
            chk($sformatf("tbl%0d rej1", i),   int'(rej1_o), int'(tbl[i].rej1));
            chk($sformatf("tbl%0d rej2", i),   int'(rej2_o), int'(tbl[i].rej2));
            chk($sformatf("tbl%0d busy", i),   int'(busy),   int'(tbl[i].busy));
        end
        @(negedge clk);
        {eu1, eu2, wt, cancel, refill} = 5'b0;
        m_credit = 60;
        do_op(OP_CANCEL, "cancel60");           // three EU2_O

        // Payout timing: 1 EUR -> five 20c pulses two cycles apart
        do_op(OP_EU1, "A eu1");
        b20 = n20;
        @(negedge clk); wt = 1'b1;
        @(posedge clk); #1;
        chk("A busy after wt", int'(busy), 1);
        chk("A no pulse yet",  int'(c20_o), 0);
        @(negedge clk); wt = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); #1;
            chk($sformatf("A c20 k%0d", k),  int'(c20_o), k % 2);
            chk($sformatf("A busy k%0d", k), int'(busy), int'(k < 10));
        end
        chk("A credit", int'(credit), 0);
        chk("A stock20", int'(stock20), 45);
        chk("A count", n20 - b20, 5);
        m_credit = 0; m_s20 -= 5;

        // 3 EUR -> fifteen 20c
        do_op(OP_REFILL, "B refill");
        do_op(OP_EU1, "B eu1");
        do_op(OP_EU2, "B eu2");
        do_op(OP_WT, "B wt");
        chk("B stock20", int'(stock20), 35);

        // Mixed change, infeasible refund, exact 10c drain
        repeat (3) do_op(OP_EU2, "C ins");
        do_op(OP_WT, "C wt30");                 // stock20 35 -> 5
        repeat (3) do_op(OP_EU2, "C ins");
        do_op(OP_WT, "C wtmix");                // 5 x20c then 50 x10c
        chk("C stock20 empty", int'(stock20), 0);
        do_op(OP_EU1, "D ins");
        do_op(OP_WT, "D infeasible");           // stock10 0 -> refund EU1
        do_op(OP_REFILL, "D refill");
        repeat (3) do_op(OP_EU2, "D ins");
        do_op(OP_WT, "D wt");
        do_op(OP_EU2, "D ins2");
        do_op(OP_EU1, "D ins3");
        do_op(OP_CANCEL, "D cancel30");         // EU2_O + EU1_O
        do_op(OP_EU1, "D ins4");
        do_op(OP_WT_COIN, "D wt+coin");

        // Coin during payout is rejected, payout unaffected
        do_op(OP_REFILL, "F refill");
        do_op(OP_EU1, "F eu1");
        b20 = n20; br1 = nr1;
        @(negedge clk); wt = 1'b1;
        @(negedge clk); wt = 1'b0;
        @(negedge clk); eu1 = 1'b1; in_units += 10;
        @(posedge clk); #1;
        chk("F rej1 while busy", int'(rej1_o), 1);
        @(negedge clk); eu1 = 1'b0;
        wait_idle("F");
        chk("F c20 count", n20 - b20, 5);
        chk("F rej count", nr1 - br1, 1);
        chk("F credit", int'(credit), 0);
        m_credit = 0; m_s20 -= 5;

        // Randomised operations against the model
        for (int i = 0; i < 150; i++) begin
            op = int'($urandom_range(0, 6));
            if (op == OP_REFILL && $urandom_range(0, 3) != 0) op = OP_WT;
            do_op(op, $sformatf("rnd%0d op%0d", i, op));
        end

        chk("ejector back-to-back", viol, 0);
        chk("20c after 10c", order_viol, 0);
        chk("conservation", n10 + 2 * n20 + 10 * ne1 + 20 * ne2 + 10 * nr1 + 20 * nr2 + int'(credit),
            in_units);

        // Reset in the middle of a payout
        do_op(OP_REFILL, "R refill");
        do_op(OP_EU2, "R eu2");
        @(negedge clk); wt = 1'b1;
        @(negedge clk); wt = 1'b0;
        repeat (3) @(negedge clk);
        chk("R busy before rst", int'(busy), 1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("R pulses", int'({c10_o, c20_o, eu1_o, eu2_o, rej1_o, rej2_o}), 0);
        chk("R busy", int'(busy), 0);
        chk("R credit", int'(credit), 0);
        chk("R stock10", int'(stock10), INIT);
        chk("R stock20", int'(stock20), INIT);
        @(negedge clk); rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/gwa_param.md
Name: gwa_param

Overview:
- Parametrised change machine and next generation of the GW-Automat block.
- Accepts 1 EUR and 2 EUR coins into a bounded credit register. On the change key it pays out 20c and 10c coins from finite, tracked coin stocks.
- If change cannot be paid exactly, it refunds the inserted euros instead. Coins over the credit limit are rejected.
- Sits between the coin-validator front end and the coin-ejector drivers.

Parameters:
- CREDIT_W, 7: credit register width, in 10c units.
- MAX_CREDIT, 60: credit limit in 10c units (6 EUR); must be < 2**CREDIT_W.
- STOCK_W, 8: width of each coin-stock counter.
- STOCK20_INIT, 50: 20c stock loaded at reset and on refill.
- STOCK10_INIT, 50: 10c stock loaded at reset and on refill.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- EU1  in  1  1 EUR inserted, one-cycle pulse.
- EU2  in  1  2 EUR inserted, one-cycle pulse.
- WT  in  1  change key.
- CANCEL  in  1  refund request.
- REFILL  in  1  reload both stocks to their INIT values.
- C10_O  out  1  eject one 10c coin.
- C20_O  out  1  eject one 20c coin.
- EU1_O  out  1  refund one 1 EUR coin.
- EU2_O  out  1  refund one 2 EUR coin.
- REJ1_O  out  1  1 EUR coin routed to the reject chute.
- REJ2_O  out  1  2 EUR coin routed to the reject chute.
- BUSY  out  1  high outside IDLE.
- CREDIT  out  CREDIT_W  current credit, in 10c units.
- STOCK10  out  STOCK_W  10c coins remaining.
- STOCK20  out  STOCK_W  20c coins remaining.

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset: state IDLE, CREDIT=0, STOCK10=STOCK10_INIT, STOCK20=STOCK20_INIT, all pulse outputs 0, BUSY=0.
- Outputs: all registered. Every ejector pulse is exactly one cycle high, followed by at least one low cycle, so consecutive coins are distinguishable by edge.
- States: IDLE, PAY_PULSE, PAY_GAP, REF_PULSE, REF_GAP.
- IDLE, coin acceptance. EU1 adds 10, EU2 adds 20, on the edge where sampled.
  - Both coins high in the same cycle: accept both if the sum fits MAX_CREDIT.
  - Otherwise accept EU1 alone if it fits, and reject EU2.
  - Otherwise reject both.
  - A rejected coin pulses REJ1_O/REJ2_O in the next cycle. CREDIT is unchanged by a rejected coin.
- IDLE, WT with CREDIT>0: decide payout using the credit value before any same-cycle coin.
  - Coins arriving in the same cycle as WT are rejected.
  - Greedy payout: n20 = min(STOCK20, CREDIT/2), r = CREDIT - 2*n20.
  - If r <= STOCK10, go to PAY_PULSE; otherwise go to REF_PULSE.
- WT or CANCEL with CREDIT=0: no action.
- IDLE, CANCEL with CREDIT>0: go to REF_PULSE. CANCEL takes priority over WT.
- PAY_PULSE:
  - If CREDIT>=2 and STOCK20>0: C20_O=1, CREDIT-=2, STOCK20-=1.
  - Otherwise: C10_O=1, CREDIT-=1, STOCK10-=1.
  - Then go to PAY_GAP.
- PAY_GAP: all outputs 0. Go to IDLE if CREDIT=0, else to PAY_PULSE.
- REF_PULSE:
  - If CREDIT>=20: EU2_O=1, CREDIT-=20.
  - Otherwise: EU1_O=1, CREDIT-=10.
  - Then go to REF_GAP. REF_GAP behaves like PAY_GAP.
  - Credit is always a multiple of 10 in refund, because it consists only of inserted euros.
- Latency: WT sampled at edge n gives BUSY=1 after edge n and the first pulse after edge n+1. For N coins, IDLE is re-entered after edge n+2N.
- Busy states: any coin arriving while BUSY is rejected via REJx_O the next cycle. WT, CANCEL and REFILL are ignored.
- REFILL: in IDLE only, reloads both stocks on the next edge.
- Stock underflow cannot occur; the feasibility check guarantees it.
- Reset mid-payout: aborts immediately to the reset values. Credit is lost; this is accepted behaviour.
- Conservation: euro value in = euro value out, counting payout, refund and reject outputs. The bench checks this.

Optional Feature:
- Macro GWA_EDGE_DET_EN.
- Defined: EU1, EU2, WT, CANCEL and REFILL pass through a rising-edge detector (one register stage). A level held for many cycles counts once, and every decision shifts one cycle later.
- Undefined: inputs are used as sampled, and the caller guarantees one-cycle pulses.

Test Plan:
- Reset, EU1, WT -> five C20_O pulses 2 cycles apart; CREDIT 10->0; STOCK20 50->45; BUSY low after the last gap.
- REFILL, EU1, EU2, WT -> fifteen C20_O pulses; STOCK20 50->35; euro balance 0.
- Drain STOCK20 to 3, then EU1, WT -> 3 C20_O then 4 C10_O; STOCK20=0, STOCK10 decreases by 4.
- STOCK20=0, STOCK10=5, EU2, WT -> infeasible, one EU2_O pulse; stocks unchanged.
- Insert EU2 three times (CREDIT=60), then EU1 -> REJ1_O pulse, CREDIT stays 60. CANCEL -> three EU2_O pulses.
- EU1 asserted during payout -> REJ1_O next cycle, payout unchanged. rst mid-payout -> all outputs 0 and stocks at INIT on the next edge.
